// File: rtl/inst_fetch_if.sv
// inst_fetch_if
//   Bundles the three channels the fetch unit talks over:
//     - PC channel      : pc_i / pc_valid_i / pc_ready_o, plus the flush_i redirect
//     - memory channel  : imem_req_o / imem_addr_o / imem_gnt_i / imem_rvalid_i / imem_rdata_i
//     - decode channel  : inst_valid_o / inst_o / inst_pc_o / inst_ready_i
//   The slave modport is the fetch unit's view. The master modport is the view of
//   everything around it: the PC register, instruction memory and decode.
//   Signal suffixes follow the fetch unit's point of view in both modports.
interface inst_fetch_if;
   logic        pc_valid_i;
   logic [31:0] pc_i;
   logic        pc_ready_o;
   logic        flush_i;

   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_ready_i;

   modport slave (
      input  pc_valid_i, pc_i, flush_i,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      input  inst_ready_i,
      output pc_ready_o,
      output imem_req_o, imem_addr_o,
      output inst_valid_o, inst_o, inst_pc_o
   );

   modport master (
      output pc_valid_i, pc_i, flush_i,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      output inst_ready_i,
      input  pc_ready_o,
      input  imem_req_o, imem_addr_o,
      input  inst_valid_o, inst_o, inst_pc_o
   );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch
//   Instruction fetch unit. It takes PCs from the PC register and issues word
//   reads to instruction memory over a request/grant handshake. Responses come
//   back in order, are paired with the PC that produced them, and are handed to
//   decode through a small output FIFO. A flush drops every fetch in flight:
//   reads that are already granted are remembered in a discard counter, so
//   their late data is thrown away when it returns.
//
// Ports
//   clk  : clock; all state changes on the rising edge
//   rst  : synchronous reset, active high
//   bus  : inst_fetch_if.slave (PC channel, memory channel, decode channel)
//
// Parameters
//   DEPTH : maximum fetches in flight, counting granted reads, buffered
//           instructions and reads waiting to be discarded (power of two, 2..8)
module inst_fetch #(
   parameter int DEPTH = 2
) (
   input logic         clk,
   input logic         rst,
   inst_fetch_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 2;

   // Request register: one address waiting for a grant
   logic             req_valid;
   logic [31:0]      req_addr;

   // PC FIFO: addresses of granted reads whose data has not come back yet
   logic [31:0]      pc_fifo [DEPTH];
   logic [PTR_W-1:0] pc_wptr;
   logic [PTR_W-1:0] pc_rptr;
   logic [CNT_W-1:0] pc_cnt;

   // Output FIFO: {pc, instruction} pairs waiting for decode
   logic [31:0]      out_pc   [DEPTH];
   logic [31:0]      out_inst [DEPTH];
   logic [PTR_W-1:0] out_wptr;
   logic [PTR_W-1:0] out_rptr;
   logic [CNT_W-1:0] out_cnt;

   // Granted reads issued before a flush whose data must be dropped
   logic [CNT_W-1:0] discard;

   logic             flush;
   logic             pc_ready;
   logic             pc_accept;
   logic             grant;
   logic             resp_keep;
   logic             resp_drop;
   logic             out_nonempty;
   logic             out_pop;
   logic [SUM_W-1:0] inflight;
   logic [SUM_W-1:0] flush_discard;

   // Credit accounting and handshake decode. The request register is left out
   // of the credit count because a new PC is only taken once it is empty; the
   // read it holds joins the PC FIFO when granted. A response is never stalled
   // because the credit limit keeps room for it in the output FIFO.
   // On a flush the discard counter absorbs every granted read whose data is
   // still to come: those in the PC FIFO, one granted in this very cycle, and
   // older discards, minus the one response consumed this cycle.
   always_comb begin
      flush         = bus.flush_i;
      inflight      = SUM_W'(pc_cnt) + SUM_W'(out_cnt) + SUM_W'(discard);
      pc_ready      = !rst && !req_valid && (inflight < SUM_W'(DEPTH)) && !flush;
      pc_accept     = bus.pc_valid_i && pc_ready;
      grant         = req_valid && bus.imem_gnt_i;
      resp_drop     = bus.imem_rvalid_i && (discard != '0);
      resp_keep     = bus.imem_rvalid_i && (discard == '0);
      out_nonempty  = (out_cnt != '0);
      out_pop       = out_nonempty && bus.inst_ready_i;
      flush_discard = SUM_W'(pc_cnt) + SUM_W'(grant) + SUM_W'(discard)
                    - SUM_W'(bus.imem_rvalid_i);
   end

   // Request register. Accept and grant never coincide because a PC is only
   // taken while the register is empty. A flush drops an ungranted request;
   // the stale address is kept since it is only visible with req low.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_valid <= 1'b0;
         req_addr  <= '0;
      end else if (flush) begin
         req_valid <= 1'b0;
      end else if (pc_accept) begin
         req_valid <= 1'b1;
         req_addr  <= bus.pc_i;
      end else if (grant) begin
         req_valid <= 1'b0;
      end
   end

   // PC FIFO storage. A read granted in a flush cycle goes to the discard
   // counter instead, so nothing is written then.
   always_ff @(posedge clk) begin
      if (grant && !flush && !rst) begin
         pc_fifo[pc_wptr] <= req_addr;
      end
   end

   // PC FIFO pointers and occupancy. Pointers wrap naturally since DEPTH is a
   // power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         pc_wptr <= '0;
         pc_rptr <= '0;
         pc_cnt  <= '0;
      end else begin
         if (grant) begin
            pc_wptr <= pc_wptr + 1'b1;
         end
         if (resp_keep) begin
            pc_rptr <= pc_rptr + 1'b1;
         end
         pc_cnt <= pc_cnt + CNT_W'(grant) - CNT_W'(resp_keep);
      end
   end

   // Output FIFO storage: a kept response is paired with the oldest granted PC.
   always_ff @(posedge clk) begin
      if (resp_keep && !flush && !rst) begin
         out_pc[out_wptr]   <= pc_fifo[pc_rptr];
         out_inst[out_wptr] <= bus.imem_rdata_i;
      end
   end

   // Output FIFO pointers and occupancy. A flush empties it regardless of a
   // same-cycle pop by decode.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_wptr <= '0;
         out_rptr <= '0;
         out_cnt  <= '0;
      end else begin
         if (resp_keep) begin
            out_wptr <= out_wptr + 1'b1;
         end
         if (out_pop) begin
            out_rptr <= out_rptr + 1'b1;
         end
         out_cnt <= out_cnt + CNT_W'(resp_keep) - CNT_W'(out_pop);
      end
   end

   // Discard counter: loaded on a flush, then counts down one per dropped
   // response. Older discards always drain before any post-flush read returns
   // because memory answers in order.
   always_ff @(posedge clk) begin
      if (rst) begin
         discard <= '0;
      end else if (flush) begin
         discard <= CNT_W'(flush_discard);
      end else if (resp_drop) begin
         discard <= discard - 1'b1;
      end
   end

   // Outputs. The instruction and PC read as zero whenever the FIFO is empty,
   // so decode never sees leftover contents.
   assign bus.pc_ready_o   = pc_ready;
   assign bus.imem_req_o   = req_valid;
   assign bus.imem_addr_o  = {req_addr[31:2], 2'b00};
   assign bus.inst_valid_o = out_nonempty;
   assign bus.inst_o       = out_nonempty ? out_inst[out_rptr] : '0;
   assign bus.inst_pc_o    = out_nonempty ? out_pc[out_rptr]   : '0;

   // A response with nothing outstanding means the memory broke the protocol.
   resp_has_owner: assert property (@(posedge clk) disable iff (rst)
      bus.imem_rvalid_i |-> ((pc_cnt != '0) || (discard != '0)));

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch
//   Directed bench for inst_fetch with DEPTH = 2. Each table row is one clock
//   cycle: the inputs driven during that cycle and the outputs expected before
//   the closing edge. Memory behaviour (grant, rvalid, data) is spelled out
//   per row; data words come from memWord(address).
module tb_inst_fetch;

   logic clk;
   logic rst;

   inst_fetch_if bus ();

   inst_fetch #(
      .DEPTH(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10 time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        pv;
      logic [31:0] pc;
      logic        fl;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_ready;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [31:0] e_ipc;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   // Instruction memory contents as a function of the word address
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return 32'hC0DE_0000 | {16'h0000, addr[15:0]};
   endfunction

   // in_bits  = {pc_valid, flush, gnt, rvalid, inst_ready}
   // exp_bits = {pc_ready, imem_req, inst_valid}
   function automatic vec_t mk(input logic [4:0] in_bits, input logic [31:0] pc,
                               input logic [31:0] rdata, input logic [2:0] exp_bits,
                               input logic [31:0] e_addr, input logic [31:0] e_ipc);
      vec_t v;
      v.pv      = in_bits[4];
      v.fl      = in_bits[3];
      v.gnt     = in_bits[2];
      v.rv      = in_bits[1];
      v.rdy     = in_bits[0];
      v.pc      = pc;
      v.rdata   = rdata;
      v.e_ready = exp_bits[2];
      v.e_req   = exp_bits[1];
      v.e_iv    = exp_bits[0];
      v.e_addr  = e_addr;
      v.e_ipc   = e_ipc;
      v.e_inst  = memWord(e_ipc);
      return v;
   endfunction

   function automatic void row(input logic [4:0] in_bits, input logic [31:0] pc,
                               input logic [31:0] rdata, input logic [2:0] exp_bits,
                               input logic [31:0] e_addr, input logic [31:0] e_ipc);
      vecs.push_back(mk(in_bits, pc, rdata, exp_bits, e_addr, e_ipc));
   endfunction

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.pc_valid_i    = v.pv;
      bus.pc_i          = v.pc;
      bus.flush_i       = v.fl;
      bus.imem_gnt_i    = v.gnt;
      bus.imem_rvalid_i = v.rv;
      bus.imem_rdata_i  = v.rdata;
      bus.inst_ready_i  = v.rdy;
   endtask

   // Compares on the falling edge; address is checked only while a request is
   // expected, instruction and PC only while an instruction is expected.
   task automatic checkOutput(input string tag, input vec_t v);
      logic ok;
      @(negedge clk);
      checks++;
      ok = (bus.pc_ready_o === v.e_ready) && (bus.imem_req_o === v.e_req) &&
           (bus.inst_valid_o === v.e_iv);
      if (v.e_req) ok = ok && (bus.imem_addr_o === v.e_addr);
      if (v.e_iv) ok = ok && (bus.inst_o === v.e_inst) && (bus.inst_pc_o === v.e_ipc);
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s: got ready=%0b req=%0b addr=%h valid=%0b inst=%h pc=%h, want ready=%0b req=%0b addr=%h valid=%0b inst=%h pc=%h",
                  tag, bus.pc_ready_o, bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o,
                  bus.inst_o, bus.inst_pc_o, v.e_ready, v.e_req, v.e_addr, v.e_iv,
                  v.e_inst, v.e_ipc);
      end
   endtask

   task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   task automatic stepRow(input string tag, input vec_t v);
      applyStimulus(v);
      checkOutput(tag, v);
      nextCycle();
   endtask

   // Global time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Straight-line fetch 0x0, 0x4, 0x8 with 1-cycle memory
      row(5'b10001, 32'h0, 32'h0,          3'b100, 32'h0, 32'h0);
      row(5'b10101, 32'h4, 32'h0,          3'b010, 32'h0, 32'h0);
      row(5'b10011, 32'h4, memWord(32'h0), 3'b100, 32'h0, 32'h0);
      row(5'b00101, 32'h0, 32'h0,          3'b011, 32'h4, 32'h0);
      row(5'b10011, 32'h8, memWord(32'h4), 3'b100, 32'h0, 32'h0);
      row(5'b00101, 32'h0, 32'h0,          3'b011, 32'h8, 32'h4);
      row(5'b00011, 32'h0, memWord(32'h8), 3'b100, 32'h0, 32'h0);
      row(5'b00001, 32'h0, 32'h0,          3'b101, 32'h0, 32'h8);
      // Decode backpressure: two fetches fill the credit, then drain in order
      row(5'b10000, 32'h20, 32'h0,           3'b100, 32'h0,  32'h0);
      row(5'b00100, 32'h0,  32'h0,           3'b010, 32'h20, 32'h0);
      row(5'b10010, 32'h24, memWord(32'h20), 3'b100, 32'h0,  32'h0);
      row(5'b00100, 32'h0,  32'h0,           3'b011, 32'h24, 32'h20);
      row(5'b10010, 32'h28, memWord(32'h24), 3'b001, 32'h0,  32'h20);
      row(5'b10000, 32'h28, 32'h0,           3'b001, 32'h0,  32'h20);
      row(5'b10001, 32'h28, 32'h0,           3'b001, 32'h0,  32'h20);
      row(5'b10001, 32'h28, 32'h0,           3'b101, 32'h0,  32'h24);
      row(5'b00101, 32'h0,  32'h0,           3'b010, 32'h28, 32'h0);
      row(5'b00011, 32'h0,  memWord(32'h28), 3'b100, 32'h0,  32'h0);
      row(5'b00001, 32'h0,  32'h0,           3'b101, 32'h0,  32'h28);
      // Flush with two granted reads outstanding, redirect to 0x100
      row(5'b10001, 32'h40,  32'h0,            3'b100, 32'h0,   32'h0);
      row(5'b00101, 32'h0,   32'h0,            3'b010, 32'h40,  32'h0);
      row(5'b10001, 32'h44,  32'h0,            3'b100, 32'h0,   32'h0);
      row(5'b00101, 32'h0,   32'h0,            3'b010, 32'h44,  32'h0);
      row(5'b11001, 32'h100, 32'h0,            3'b000, 32'h0,   32'h0);
      row(5'b10011, 32'h100, memWord(32'h40),  3'b000, 32'h0,   32'h0);
      row(5'b10011, 32'h100, memWord(32'h44),  3'b100, 32'h0,   32'h0);
      row(5'b00101, 32'h0,   32'h0,            3'b010, 32'h100, 32'h0);
      row(5'b00011, 32'h0,   memWord(32'h100), 3'b100, 32'h0,   32'h0);
      row(5'b00001, 32'h0,   32'h0,            3'b101, 32'h0,   32'h100);
      // Flush in the same cycle as a grant and a response (2-cycle memory)
      row(5'b10001, 32'h60, 32'h0,           3'b100, 32'h0,  32'h0);
      row(5'b00101, 32'h0,  32'h0,           3'b010, 32'h60, 32'h0);
      row(5'b10001, 32'h64, 32'h0,           3'b100, 32'h0,  32'h0);
      row(5'b11111, 32'h80, memWord(32'h60), 3'b010, 32'h64, 32'h0);
      row(5'b10001, 32'h80, 32'h0,           3'b100, 32'h0,  32'h0);
      row(5'b00111, 32'h0,  memWord(32'h64), 3'b010, 32'h80, 32'h0);
      row(5'b00001, 32'h0,  32'h0,           3'b100, 32'h0,  32'h0);
      row(5'b00011, 32'h0,  memWord(32'h80), 3'b100, 32'h0,  32'h0);
      row(5'b00001, 32'h0,  32'h0,           3'b101, 32'h0,  32'h80);
      row(5'b00001, 32'h0,  32'h0,           3'b100, 32'h0,  32'h0);
      // Flush with nothing in flight only blocks pc_ready for that cycle
      row(5'b11001, 32'h90, 32'h0,           3'b000, 32'h0,  32'h0);
      row(5'b10001, 32'h90, 32'h0,           3'b100, 32'h0,  32'h0);
      row(5'b00101, 32'h0,  32'h0,           3'b010, 32'h90, 32'h0);
      row(5'b00011, 32'h0,  memWord(32'h90), 3'b100, 32'h0,  32'h0);
      row(5'b00001, 32'h0,  32'h0,           3'b101, 32'h0,  32'h90);

      // Reset: pc_ready low while held, everything zero after release
      rst = 1'b1;
      applyStimulus(mk(5'b00000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0));
      nextCycle();
      nextCycle();
      stepRow("reset_held", mk(5'b00000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0));
      rst = 1'b0;
      applyStimulus(mk(5'b00001, 32'h0, 32'h0, 3'b100, 32'h0, 32'h0));
      checkOutput("reset_release", mk(5'b00001, 32'h0, 32'h0, 3'b100, 32'h0, 32'h0));
      checkValue("reset_addr", bus.imem_addr_o, 32'h0);
      checkValue("reset_inst", bus.inst_o, 32'h0);
      checkValue("reset_inst_pc", bus.inst_pc_o, 32'h0);
      nextCycle();

      $display("[TB] running %0d table vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         stepRow($sformatf("vec%0d", i), vecs[i]);
      end

      // Grant stall: request for 0x10 held for four cycles without a grant
      stepRow("stall_accept", mk(5'b10001, 32'h10, 32'h0, 3'b100, 32'h0, 32'h0));
      for (int i = 0; i < 4; i++) begin
         stepRow($sformatf("stall_hold%0d", i), mk(5'b10001, 32'h14, 32'h0, 3'b010, 32'h10, 32'h0));
      end
      stepRow("stall_grant", mk(5'b00101, 32'h0, 32'h0, 3'b010, 32'h10, 32'h0));
      stepRow("stall_resp", mk(5'b00011, 32'h0, memWord(32'h10), 3'b100, 32'h0, 32'h0));
      stepRow("stall_deliver", mk(5'b00001, 32'h0, 32'h0, 3'b101, 32'h0, 32'h10));

      // Reset with one instruction buffered and one request pending
      stepRow("midrst_accept0", mk(5'b10001, 32'h30, 32'h0, 3'b100, 32'h0, 32'h0));
      stepRow("midrst_grant0", mk(5'b00100, 32'h0, 32'h0, 3'b010, 32'h30, 32'h0));
      stepRow("midrst_accept1", mk(5'b10010, 32'h34, memWord(32'h30), 3'b100, 32'h0, 32'h0));
      rst = 1'b1;
      stepRow("midrst_assert", mk(5'b00000, 32'h0, 32'h0, 3'b011, 32'h34, 32'h30));
      rst = 1'b0;
      applyStimulus(mk(5'b00001, 32'h0, 32'h0, 3'b100, 32'h0, 32'h0));
      checkOutput("midrst_after", mk(5'b00001, 32'h0, 32'h0, 3'b100, 32'h0, 32'h0));
      checkValue("midrst_addr", bus.imem_addr_o, 32'h0);
      checkValue("midrst_inst", bus.inst_o, 32'h0);
      checkValue("midrst_inst_pc", bus.inst_pc_o, 32'h0);
      nextCycle();
      stepRow("post_accept", mk(5'b10001, 32'h0, 32'h0, 3'b100, 32'h0, 32'h0));
      stepRow("post_grant", mk(5'b00101, 32'h0, 32'h0, 3'b010, 32'h0, 32'h0));
      stepRow("post_resp", mk(5'b00011, 32'h0, memWord(32'h0), 3'b100, 32'h0, 32'h0));
      stepRow("post_deliver", mk(5'b00001, 32'h0, 32'h0, 3'b101, 32'h0, 32'h0));
      stepRow("post_idle", mk(5'b00001, 32'h0, 32'h0, 3'b100, 32'h0, 32'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the RISC-V core. It consumes the PC stream produced by the PC register and issues word reads to instruction memory over a request/grant interface. In-order responses are paired with their PCs, and each instruction/PC pair is delivered to decode through a small elastic buffer. Branch redirects flush all in-flight fetches, so no stale instruction reaches decode.

## Interface
- DEPTH, 2: maximum fetches in flight, counting outstanding memory reads plus buffered instructions. Power of two, 2..8.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- pc_i  in  32  fetch address from PC register.
- pc_valid_i  in  1  pc_i is valid this cycle.
- pc_ready_o  out  1  fetch unit accepts pc_i this cycle.
- flush_i  in  1  branch redirect; discard everything in flight.
- imem_req_o  out  1  read request to instruction memory.
- imem_addr_o  out  32  request word address; bits [1:0] forced to 0.
- imem_gnt_i  in  1  memory accepted request this cycle.
- imem_rvalid_i  in  1  read data valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata_i  in  32  read data.
- inst_valid_o  out  1  instruction available to decode.
- inst_o  out  32  instruction word.
- inst_pc_o  out  32  PC of inst_o.
- inst_ready_i  in  1  decode consumes inst_o this cycle.

## Operation
- State:
  - Request register (valid, addr).
  - PC FIFO of granted addresses, DEPTH entries.
  - Output FIFO of {pc, inst}, DEPTH entries.
  - Discard counter, 0..DEPTH.
- Credit: inflight = PC FIFO count + output FIFO count + discard counter.
- pc_ready_o = !req_valid && inflight < DEPTH && !flush_i.
- PC accept (pc_valid_i && pc_ready_o): load req_valid=1 and req_addr=pc_i.
- Request: imem_req_o = req_valid, imem_addr_o = {req_addr[31:2], 2'b00}. Held stable until imem_gnt_i.
- Grant (imem_req_o && imem_gnt_i): push req_addr to PC FIFO and clear req_valid.
- Response (imem_rvalid_i):
  - If discard counter > 0: decrement it and drop the data.
  - Otherwise: pop the PC FIFO head and push {head, imem_rdata_i} to the output FIFO.
  - The credit rule guarantees space, so a response is never lost or stalled.
- Output: inst_valid_o = output FIFO not empty; inst_o and inst_pc_o come from its head. Pop on inst_valid_o && inst_ready_i.
- Flush (flush_i=1), applied at the edge:
  - Output FIFO cleared.
  - Ungranted request dropped (req_valid=0).
  - Discard counter = PC FIFO count + (1 if granted this cycle) + current discard − (1 if rvalid this cycle).
  - PC FIFO cleared.
  - A same-cycle inst_ready_i pop is irrelevant.
- Flush while a request is granted in the same cycle: that read counts as discard; its data is dropped when it returns.
- Flush with no activity in flight: no effect besides blocking pc_ready_o for that cycle.
- Response with PC FIFO empty and discard=0 is a protocol violation; assert in simulation.

## Timing
- Reset values: pc_ready_o=0 during reset, then 1. imem_req_o=0, imem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0. All FIFOs empty, discard=0.
- PC accepted at edge N → imem_req_o high in cycle N+1.
- Grant in cycle N+1 → earliest rvalid in N+2 → inst_valid_o in N+3. Minimum latency: 3 cycles from accept to decode-visible.
- Throughput: with grant every cycle and 1-cycle memory, DEPTH≥2 sustains 1 instruction every 2 cycles. The request register serialises accept and grant, so back-to-back requests occur only in alternating cycles.
- Output FIFO full with decode stalled: inflight reaches DEPTH and pc_ready_o drops. No new requests issue.
- Flush takes effect at the edge. The first post-flush PC can be accepted the cycle after flush_i.
- Reset mid-operation clears all state; late responses after reset are ignored only if the memory is also reset.

## Test plan
- Straight-line fetch: PCs 0x0, 0x4, 0x8, memory 1-cycle latency, always grant, inst_ready_i=1 → decode sees (0x0, mem[0]), (0x4, mem[1]), (0x8, mem[2]) in order; first inst_valid_o exactly 3 cycles after the first accept.
- Grant stall: hold imem_gnt_i=0 for 4 cycles on pc 0x10 → imem_addr_o stays 0x10, imem_req_o stays high, pc_ready_o stays 0; after grant, inst_pc_o=0x10.
- Decode backpressure: inst_ready_i=0, DEPTH=2 → after 2 fetches pc_ready_o=0 and imem_req_o=0; releasing ready delivers both instructions in order with no loss.
- Flush with 2 outstanding (2-cycle memory latency), redirect to 0x100 → both late responses dropped; the first delivered instruction has inst_pc_o=0x100.
- Flush in the same cycle as a grant and an rvalid → discard count correct, zero stale instructions delivered, the next fetch completes normally.
- Reset asserted with data in flight → all outputs 0 the next cycle; fetch from 0x0 works after release.
